// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction and FSM encodings, start-up
// coordinates and the segment half-size used by the renderer.
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_t;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StOver = 2'd2;

    localparam logic [9:0] InitX [4] = '{10'd320, 10'd310, 10'd300, 10'd290};
    localparam logic [9:0] InitY [4] = '{10'd240, 10'd240, 10'd240, 10'd240};

    localparam int unsigned SegHalf = 5;

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return ((a == DirUp)   && (b == DirDown))  || ((a == DirDown)  && (b == DirUp)) ||
               ((a == DirLeft) && (b == DirRight)) || ((a == DirRight) && (b == DirLeft));
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Counts frame ticks while enabled and strobes once every STEP_FRAMES ticks.
module snake_step_timer #(
    parameter int STEP_FRAMES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic frame_tick_i,
    output logic strobe_o
);

    localparam int CntW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    always_comb begin
        wrap     = (cnt_q == CntW'(STEP_FRAMES - 1));
        strobe_o = en_i && frame_tick_i && wrap;
        cnt_d    = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (frame_tick_i) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_motion.sv
// Snake head/body motion: button decode, IDLE/RUN/OVER control and the
// four-segment position shift register.
module snake_motion
    import snake_pkg::*;
#(
    parameter int STEP_FRAMES = 8,
    parameter int STEP_PX     = 10,
    parameter int X_MIN       = 5,
    parameter int X_MAX       = 634,
    parameter int Y_MIN       = 5,
    parameter int Y_MAX       = 474
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] snake_x1,
    output logic [9:0] snake_y1,
    output logic [9:0] snake_x2,
    output logic [9:0] snake_y2,
    output logic [9:0] snake_x3,
    output logic [9:0] snake_y3,
    output logic [9:0] snake_x4,
    output logic [9:0] snake_y4,
    output logic       black,
    output logic       step
);

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, pend_q, pend_d, btn_dir, move_dir;
    logic [3:0] btn_q, btns;
    logic [9:0] x_q [4];
    logic [9:0] x_d [4];
    logic [9:0] y_q [4];
    logic [9:0] y_d [4];
    logic       step_q, step_d, black_q, black_d;
    logic       btn_any, btn_rise, move_strobe, move_ok;
    int         nx, ny;

    snake_step_timer #(
        .STEP_FRAMES(STEP_FRAMES)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (state_q == StRun),
        .frame_tick_i(frame_tick),
        .strobe_o    (move_strobe)
    );

    always_comb begin
        btns     = {btn_up, btn_down, btn_left, btn_right};
        btn_any  = |btns;
        btn_rise = |(btns & ~btn_q);
        if (btn_up)        btn_dir = DirUp;
        else if (btn_down) btn_dir = DirDown;
        else if (btn_left) btn_dir = DirLeft;
        else               btn_dir = DirRight;

        move_dir = is_opposite(pend_q, dir_q) ? dir_q : pend_q;
        // Signed arithmetic so a head near the low edge cannot wrap to a huge coordinate.
        nx = int'(x_q[0]);
        ny = int'(y_q[0]);
        unique case (move_dir)
            DirUp:    ny = ny - STEP_PX;
            DirDown:  ny = ny + STEP_PX;
            DirLeft:  nx = nx - STEP_PX;
            DirRight: nx = nx + STEP_PX;
        endcase
        move_ok = (nx >= X_MIN) && (nx <= X_MAX) && (ny >= Y_MIN) && (ny <= Y_MAX);

        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = btn_any ? btn_dir : pend_q;
        x_d     = x_q;
        y_d     = y_q;
        step_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (btn_any) begin
                    state_d = StRun;
                    if (!is_opposite(btn_dir, dir_q)) dir_d = btn_dir;
                end
            end
            StRun: begin
                if (move_strobe) begin
                    if (move_ok) begin
                        x_d    = '{10'(nx), x_q[0], x_q[1], x_q[2]};
                        y_d    = '{10'(ny), y_q[0], y_q[1], y_q[2]};
                        step_d = 1'b1;
                        dir_d  = move_dir;
                    end else begin
                        state_d = StOver;
                    end
                end
            end
            StOver: begin
                // Restart facing right so the first move never runs into the body.
                if (btn_rise) begin
                    state_d = StIdle;
                    x_d     = InitX;
                    y_d     = InitY;
                    dir_d   = DirRight;
                    pend_d  = DirRight;
                end
            end
            default: state_d = StIdle;
        endcase

        black_d = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DirRight;
            pend_q  <= DirRight;
            btn_q   <= '0;
            x_q     <= InitX;
            y_q     <= InitY;
            step_q  <= 1'b0;
            black_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            btn_q   <= btns;
            x_q     <= x_d;
            y_q     <= y_d;
            step_q  <= step_d;
            black_q <= black_d;
        end
    end

    assign snake_x1 = x_q[0];
    assign snake_y1 = y_q[0];
    assign snake_x2 = x_q[1];
    assign snake_y2 = y_q[1];
    assign snake_x3 = x_q[2];
    assign snake_y3 = y_q[2];
    assign snake_x4 = x_q[3];
    assign snake_y4 = y_q[3];
    assign black    = black_q;
    assign step     = step_q;

endmodule

// File: tb/tb_snake_motion.sv
// Directed vector table, corner sequences and random stimulus against a
// coordinate-level model of the snake game rules.
module tb_snake_motion;

    localparam int SF = 8, PX = 10, XMIN = 5, XMAX = 634, YMIN = 5, YMAX = 474;

    logic       clk = 0, rst = 0, frame_tick = 0;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic [9:0] snake_x1, snake_y1, snake_x2, snake_y2;
    logic [9:0] snake_x3, snake_y3, snake_x4, snake_y4;
    logic       black, step;

    snake_motion dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .snake_x1  (snake_x1),
        .snake_y1  (snake_y1),
        .snake_x2  (snake_x2),
        .snake_y2  (snake_y2),
        .snake_x3  (snake_x3),
        .snake_y3  (snake_y3),
        .snake_x4  (snake_x4),
        .snake_y4  (snake_y4),
        .black     (black),
        .step      (step)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, steps_seen = 0;

    // Model: 0 = waiting, 1 = running, 2 = game over; directions 0 up, 1 down, 2 left, 3 right.
    int   m_state, m_dir, m_pend, m_cnt;
    int   m_x [4];
    int   m_y [4];
    bit   m_step, m_black;
    logic [3:0] m_prev;
    int   DX [4] = '{0, 0, -1, 1};
    int   DY [4] = '{-1, 1, 0, 0};

    function automatic bit opp(input int a, input int b);
        return ((a < 2) == (b < 2)) && (a != b);
    endfunction

    task automatic model_reset();
        m_state = 0; m_dir = 3; m_pend = 3; m_cnt = 0;
        m_step = 0; m_black = 0; m_prev = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_x[i] = 320 - 10 * i;
            m_y[i] = 240;
        end
    endtask

    task automatic model(input bit r, input logic [3:0] b, input bit t);
        int  win, md, nx, ny;
        bit  restart;
        if (r) begin
            model_reset();
            return;
        end
        m_step  = 0;
        restart = 0;
        win = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
        case (m_state)
            0: if (b != 0) begin
                m_state = 1;
                if (!opp(win, m_dir)) m_dir = win;
            end
            1: if (t) begin
                if (m_cnt == SF - 1) begin
                    m_cnt = 0;
                    md = opp(m_pend, m_dir) ? m_dir : m_pend;
                    nx = m_x[0] + DX[md] * PX;
                    ny = m_y[0] + DY[md] * PX;
                    if (nx < XMIN || nx > XMAX || ny < YMIN || ny > YMAX) begin
                        m_state = 2;
                    end else begin
                        for (int i = 3; i > 0; i--) begin
                            m_x[i] = m_x[i-1];
                            m_y[i] = m_y[i-1];
                        end
                        m_x[0] = nx; m_y[0] = ny; m_step = 1; m_dir = md;
                    end
                end else begin
                    m_cnt++;
                end
            end
            default: if ((b & ~m_prev) != 0) begin
                model_reset();
                restart = 1;
            end
        endcase
        if (b != 0 && !restart) m_pend = win;
        m_black = (m_state == 2);
        m_prev  = b;
    endtask

    task automatic check_all();
        int ax [4];
        int ay [4];
        bit bad;
        ax = '{int'(snake_x1), int'(snake_x2), int'(snake_x3), int'(snake_x4)};
        ay = '{int'(snake_y1), int'(snake_y2), int'(snake_y3), int'(snake_y4)};
        bad = (step !== m_step) || (black !== m_black);
        for (int i = 0; i < 4; i++) if (ax[i] != m_x[i] || ay[i] != m_y[i]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL model t=%0t got x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d step=%0b black=%0b want x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d step=%0b black=%0b",
                     $time, ax[0], ax[1], ax[2], ax[3], ay[0], ay[1], ay[2], ay[3], step, black,
                     m_x[0], m_x[1], m_x[2], m_x[3], m_y[0], m_y[1], m_y[2], m_y[3], m_step, m_black);
        end
    endtask

    task automatic cyc(input bit r, input logic [3:0] b, input bit t);
        rst = r;
        {btn_up, btn_down, btn_left, btn_right} = b;
        frame_tick = t;
        @(posedge clk);
        model(r, b, t);
        #1;
        if (step === 1'b1) steps_seen++;
        check_all();
    endtask

    task automatic expect_pos(input string name, input bit ok, input int ax, input int ay,
                              input int ex, input int ey);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got x1=%0d y1=%0d step=%0b black=%0b want x1=%0d y1=%0d",
                     name, ax, ay, step, black, ex, ey);
        end
    endtask

    typedef struct {
        bit         rs;
        logic [3:0] b;
        bit         hold;
        int         nt;
        int         x1, y1, x2, y2;
        bit         blk;
        int         nsteps;
    } row_t;

    row_t rows [8];

    initial begin
        // {reset first, buttons {up,down,left,right}, hold during ticks, ticks, x1,y1,x2,y2, black, steps}
        rows[0] = '{0, 4'b0000, 0, 100, 320, 240, 310, 240, 0, 0};
        rows[1] = '{0, 4'b0001, 0, 8,   330, 240, 320, 240, 0, 1};
        rows[2] = '{0, 4'b0010, 1, 8,   340, 240, 330, 240, 0, 1};
        rows[3] = '{0, 4'b1010, 0, 8,   340, 230, 340, 240, 0, 1};
        rows[4] = '{1, 4'b0001, 0, 248, 630, 240, 620, 240, 0, 31};
        rows[5] = '{0, 4'b0000, 0, 8,   630, 240, 620, 240, 1, 0};
        rows[6] = '{0, 4'b0100, 0, 0,   320, 240, 310, 240, 0, 0};
        rows[7] = '{0, 4'b0001, 0, 256, 630, 240, 620, 240, 1, 31};

        cyc(1, 4'b0, 0);
        cyc(1, 4'b0, 0);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] hb;
            if (rows[i].rs) cyc(1, 4'b0, 0);
            steps_seen = 0;
            cyc(0, rows[i].b, 0);
            hb = rows[i].hold ? rows[i].b : 4'b0;
            for (int k = 0; k < rows[i].nt; k++) begin
                cyc(0, hb, 1);
                cyc(0, hb, 0);
            end
            checks++;
            if (int'(snake_x1) != rows[i].x1 || int'(snake_y1) != rows[i].y1 ||
                int'(snake_x2) != rows[i].x2 || int'(snake_y2) != rows[i].y2 ||
                black !== rows[i].blk || steps_seen != rows[i].nsteps) begin
                errors++;
                $display("FAIL row%0d got x1=%0d y1=%0d x2=%0d y2=%0d black=%0b steps=%0d want %0d %0d %0d %0d %0b %0d",
                         i, snake_x1, snake_y1, snake_x2, snake_y2, black, steps_seen,
                         rows[i].x1, rows[i].y1, rows[i].x2, rows[i].y2, rows[i].blk,
                         rows[i].nsteps);
            end
        end

        // Held button from game over: one restart, then it only starts a run.
        for (int k = 0; k < 10; k++) cyc(0, 4'b0100, 0);
        expect_pos("held_restart", snake_x1 == 10'd320 && snake_y1 == 10'd240 && black == 1'b0,
                   int'(snake_x1), int'(snake_y1), 320, 240);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 4'b0, 1);
            cyc(0, 4'b0, 0);
        end
        expect_pos("down_step", snake_x1 == 10'd320 && snake_y1 == 10'd250 &&
                   snake_y2 == 10'd240, int'(snake_x1), int'(snake_y1), 320, 250);

        // Reset collides with the move strobe.
        for (int k = 0; k < 7; k++) begin
            cyc(0, 4'b0, 1);
            cyc(0, 4'b0, 0);
        end
        cyc(1, 4'b0, 1);
        expect_pos("rst_vs_move", step == 1'b0 && snake_x1 == 10'd320 && snake_y1 == 10'd240 &&
                   snake_x4 == 10'd290 && black == 1'b0, int'(snake_x1), int'(snake_y1), 320, 240);
        cyc(0, 4'b0, 0);
        expect_pos("no_late_step", step == 1'b0 && snake_y1 == 10'd240,
                   int'(snake_x1), int'(snake_y1), 320, 240);

        for (int n = 0; n < 20000; n++) begin
            bit         r, t;
            logic [3:0] b;
            r = ($urandom_range(0, 999) == 0);
            b = ($urandom_range(0, 47) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            t = ($urandom_range(0, 3) != 0);
            cyc(r, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_motion.md
SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 Parameter STEP_FRAMES, default 8, frame ticks per snake step.
REQ-002 Parameter STEP_PX, default 10, pixels moved per step.
REQ-003 Parameter X_MIN / X_MAX, defaults 5 / 634, legal head-centre x range, inclusive.
REQ-004 Parameter Y_MIN / Y_MAX, defaults 5 / 474, legal head-centre y range, inclusive.
REQ-005 Ports shall be:
  clk  input  1  system clock
  rst  input  1  synchronous active-high reset
  frame_tick  input  1  one-cycle pulse once per video frame
  btn_up  input  1  debounced level, up request
  btn_down  input  1  debounced level, down request
  btn_left  input  1  debounced level, left request
  btn_right  input  1  debounced level, right request
  snake_x1, snake_y1  output  10 each  head centre
  snake_x2..snake_x4, snake_y2..snake_y4  output  10 each  body centres, 4 = tail
  black  output  1  game-over blanking flag to the display stage
  step  output  1  one-cycle pulse on each applied move
REQ-006 All outputs shall be registered.

Function
REQ-007 FSM states IDLE, RUN, OVER; encoding is free.
REQ-008 IDLE: segments hold their initial positions; any button high -> RUN next cycle, and that button sets the direction subject to REQ-012.
REQ-009 RUN: a frame counter increments on frame_tick; when it reaches STEP_FRAMES-1 together with a frame_tick, it clears, and a move occurs in that same cycle.
REQ-010 Move: seg4<=seg3, seg3<=seg2, seg2<=seg1, seg1<=seg1 +/- STEP_PX on the axis of the current direction; step=1 for that cycle only.
REQ-011 Button priority when several are high: up > down > left > right; the winner is latched into pending_dir on any cycle and is applied to direction only at the next move.
REQ-012 A pending direction opposite to the current direction shall be ignored (no reversal).
REQ-013 Boundary: if the move would place the head outside [X_MIN,X_MAX] or [Y_MIN,Y_MAX], no segment changes, step stays 0, and the FSM -> OVER.
REQ-014 The boundary test shall be done without unsigned wrap (e.g. left illegal when x1 < X_MIN+STEP_PX).
REQ-015 OVER: black=1 and positions are frozen; a rising edge on any button (low in previous cycle, high now) -> IDLE with initial positions and black=0 next cycle.
REQ-016 black=0 in IDLE and RUN.
REQ-017 The frame counter shall be held at 0 in IDLE and OVER.
REQ-018 Self-collision is not detected; it is unreachable with 4 segments and no reversal.

Reset
REQ-019 On rst: state IDLE; direction and pending_dir = right; frame counter 0; step 0; black 0.
REQ-020 On rst: (x1..x4) = (320,310,300,290); y1..y4 = 240.
REQ-021 rst asserted mid-move or in OVER shall take priority over all other updates in that cycle.

Structure
REQ-022 Shared package snake_pkg: direction encoding (UP, DOWN, LEFT, RIGHT), FSM state type, initial coordinate constants, and segment half-size 5 (also used by the display stage).
REQ-023 One sub-module, snake_step_timer: frame counter producing the move strobe.
REQ-024 Direction decode, FSM, and the segment shift register stay in snake_motion.

Verification
REQ-025 Reset, no buttons, 100 frame_ticks -> positions (320,240),(310,240),(300,240),(290,240); black=0; step never 1.
REQ-026 btn_right pulse, then 8 frame_ticks -> exactly one step pulse; x1..x4 = 330,320,310,300.
REQ-027 In RUN moving right, btn_left held -> ignored; next step x1 += 10. Then btn_up+btn_left together -> next step y1 = 230, y2 = 240.
REQ-028 Running right from reset -> 31 steps reach x1=630; next move -> OVER, black=1, x1 stays 630, step=0.
REQ-029 In OVER, btn_down rising edge -> next cycle IDLE, black=0, initial positions restored; a held button after reset of positions causes no second restart.
REQ-030 rst asserted in the same cycle as a move strobe -> reset values, no step pulse.
